// File: rtl/top_level.sv
// rtl/top_level.sv - accumulator processor with built-in program and 8N1 UART dump of ACC on halt
module top_level #(
  parameter int NB_INSTRUCTION  = 16,
  parameter int NB_ADDR         = 11,
  parameter int NB_OPCODE       = 5,
  parameter int NB_OPERAND      = NB_INSTRUCTION - NB_OPCODE,
  parameter int NB_DATA         = 8,
  parameter int NB_STOP         = 1,
  parameter int BAUD_RATE       = 9600,
  parameter int SYS_CLOCK       = 100000000,
  parameter int TICK_RATE       = SYS_CLOCK / (BAUD_RATE * 16),
  parameter int NB_TICK_COUNTER = $clog2(TICK_RATE),
  parameter int NB_DATA_COUNTER = $clog2(NB_DATA)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  output logic                      RsTx,
  output logic [NB_INSTRUCTION-1:0] o_led
);

  localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

  localparam logic [NB_TICK_COUNTER-1:0] TICK_LAST = NB_TICK_COUNTER'(TICK_RATE - 1);
  localparam logic [NB_DATA_COUNTER-1:0] DATA_LAST = NB_DATA_COUNTER'(NB_DATA - 1);
  localparam logic [NB_DATA_COUNTER-1:0] STOP_LAST = NB_DATA_COUNTER'(NB_STOP - 1);

  logic [NB_ADDR-1:0]        pc;
  logic [NB_INSTRUCTION-1:0] acc;
  logic                      halted;
  logic [NB_INSTRUCTION-1:0] instr;
  logic [NB_OPCODE-1:0]      opcode;
  logic [NB_OPERAND-1:0]     operand;
  logic [NB_ADDR-1:0]        addr;
  logic [NB_INSTRUCTION-1:0] imm;
  logic [NB_INSTRUCTION-1:0] mem_rd;

  logic [NB_INSTRUCTION-1:0] data_mem [2**NB_ADDR] = '{default: '0};

  always_comb begin
    instr = '0;
    case (pc)
      NB_ADDR'(0): instr = {OP_LDI,  NB_OPERAND'(5)};
      NB_ADDR'(1): instr = {OP_STO,  NB_OPERAND'(0)};
      NB_ADDR'(2): instr = {OP_ADDI, NB_OPERAND'(3)};
      NB_ADDR'(3): instr = {OP_ADD,  NB_OPERAND'(0)};
      NB_ADDR'(4): instr = {OP_SUBI, NB_OPERAND'(1)};
      NB_ADDR'(5): instr = {OP_STO,  NB_OPERAND'(1)};
      NB_ADDR'(6): instr = {OP_SUB,  NB_OPERAND'(0)};
      NB_ADDR'(7): instr = {OP_LD,   NB_OPERAND'(1)};
      default:     instr = '0;
    endcase
  end

  assign opcode  = instr[NB_INSTRUCTION-1 -: NB_OPCODE];
  assign operand = instr[NB_OPERAND-1:0];
  assign addr    = operand[NB_ADDR-1:0];
  assign imm     = {{(NB_INSTRUCTION-NB_OPERAND){operand[NB_OPERAND-1]}}, operand};
  assign mem_rd  = data_mem[addr];
  assign o_led   = acc;

  // RAM contents survive reset; only the write port is gated by it
  always_ff @(posedge i_clock) begin
    if (!i_reset && !halted && opcode == OP_STO)
      data_mem[addr] <= acc;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc     <= '0;
      acc    <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        pc <= pc + 1'b1;
        case (opcode)
          OP_LD:   acc <= mem_rd;
          OP_LDI:  acc <= imm;
          OP_ADD:  acc <= acc + mem_rd;
          OP_ADDI: acc <= acc + imm;
          OP_SUB:  acc <= acc - mem_rd;
          OP_SUBI: acc <= acc - imm;
          default: acc <= acc;
        endcase
      end
    end
  end

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t                  tx_state;
  logic [NB_TICK_COUNTER-1:0] tick_cnt;
  logic                       tick;
  logic [3:0]                 sample_cnt;
  logic [NB_DATA_COUNTER-1:0] bit_cnt;
  logic [NB_DATA-1:0]         shift;
  logic                       second_byte;
  logic                       tx_done;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // all line transitions land on tick edges, so each bit is exactly 16 ticks
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tx_state    <= TX_IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      second_byte <= 1'b0;
      tx_done     <= 1'b0;
      RsTx        <= 1'b1;
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          RsTx <= 1'b1;
          if (halted && !tx_done) begin
            tx_state    <= TX_START;
            RsTx        <= 1'b0;
            shift       <= acc[NB_INSTRUCTION-1 -: NB_DATA];
            second_byte <= 1'b0;
            sample_cnt  <= '0;
          end
        end
        TX_START: begin
          if (sample_cnt == 4'd15) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            tx_state   <= TX_DATA;
            RsTx       <= shift[0];
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (sample_cnt == 4'd15) begin
            sample_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt  <= '0;
              tx_state <= TX_STOP;
              RsTx     <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              RsTx    <= shift[1];
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (sample_cnt == 4'd15) begin
            sample_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (!second_byte) begin
                second_byte <= 1'b1;
                tx_state    <= TX_START;
                RsTx        <= 1'b0;
                shift       <= acc[NB_DATA-1:0];
              end else begin
                tx_done  <= 1'b1;
                tx_state <= TX_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - self-checking bench for top_level with scaled-down baud clock
module tb_top_level;

  // 768 kHz system clock gives 5 clocks per tick, 80 clocks per bit at 9600 baud
  localparam int TR    = 5;
  localparam int BIT   = 16 * TR;
  localparam int QUIET = 8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx;
  logic [15:0] led;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int halt_cyc;

  logic [7:0]  byte_q [$];
  logic [15:0] exp_acc [9] = '{16'd5, 16'd5, 16'd8, 16'd13, 16'd12, 16'd12, 16'd7, 16'd12, 16'd12};

  top_level #(.SYS_CLOCK(768000)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .RsTx    (tx),
    .o_led   (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("reset_led", 32'(led), 32'h0);
      check("reset_tx", 32'(tx), 32'h1);
    end
    rst = 1'b0;
  endtask

  task automatic run_program();
    byte_q.push_back(8'h00);
    byte_q.push_back(8'h0C);
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);
      check($sformatf("led_edge%0d", e + 1), 32'(led), 32'(exp_acc[e]));
    end
    check("tx_high_at_halt", 32'(tx), 32'h1);
    halt_cyc = cyc;
  endtask

  task automatic wait_fall(input int limit, input string tag, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'h1);
  endtask

  // samples mid-bit; k counts negedges since the one that first saw the start bit
  task automatic rx_frame(output logic [7:0] b, output int first_change);
    int idx;
    b = '0;
    first_change = -1;
    for (int k = 1; k < 10 * BIT; k++) begin
      @(negedge clk);
      if (first_change < 0 && tx !== 1'b0) first_change = k;
      if (k % BIT == BIT / 2) begin
        idx = k / BIT;
        if (idx == 0) check("start_bit", 32'(tx), 32'h0);
        else if (idx == 9) check("stop_bit", 32'(tx), 32'h1);
        else b[idx-1] = tx;
      end
    end
  endtask

  task automatic score_byte(input logic [7:0] b);
    if (byte_q.size() == 0) check("scoreboard_empty", 32'h1, 32'h0);
    else check("uart_byte", 32'(b), 32'(byte_q.pop_front()));
  endtask

  task automatic rx_two_frames(input bit check_timing);
    bit         ok;
    logic [7:0] b;
    int         fc;
    wait_fall(TR + 1, "start_latency", ok);
    if (ok) begin
      rx_frame(b, fc);
      score_byte(b);
    end else begin
      void'(byte_q.pop_front());
    end
    wait_fall(TR + 1, "second_start_gap", ok);
    if (ok) begin
      rx_frame(b, fc);
      score_byte(b);
      if (check_timing) check("bit_timing_3bits", 32'(fc), 32'(3 * BIT));
    end else begin
      void'(byte_q.pop_front());
    end
  endtask

  task automatic quiet_window(input int n);
    bit bad = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || led !== 16'h000C) bad = 1'b1;
    end
    check("no_retransmit", 32'(bad), 32'h0);
  endtask

  initial begin
    bit ok;

    do_reset(3);
    run_program();
    rx_two_frames(1'b1);
    quiet_window(QUIET);

    do_reset(2);
    run_program();
    rx_two_frames(1'b0);
    quiet_window(BIT);

    // abort inside data bit 4 of the second frame (a 0 bit of 0x0C)
    do_reset(2);
    run_program();
    wait_fall(TR + 1, "start_latency", ok);
    if (ok) begin
      repeat (10 * BIT - 1) @(negedge clk);
      score_byte(8'h00);
    end else begin
      void'(byte_q.pop_front());
    end
    wait_fall(TR + 1, "second_start_gap", ok);
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    check("abort_pre_tx_low", 32'(tx), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_high", 32'(tx), 32'h1);
    check("abort_led_zero", 32'(led), 32'h0);
    void'(byte_q.pop_front());
    do_reset(1);
    run_program();
    rx_two_frames(1'b1);
    quiet_window(2 * BIT);

    check("scoreboard_drained", 32'(byte_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/top_level.md
# top_level

Top-level of a minimal accumulator processor (BIP-class) with a UART transmitter. The processor executes a built-in program from an internal program ROM and drives the accumulator on the LEDs. On reaching a halt instruction it sends the 16-bit accumulator over the serial line (8N1), then stays halted until reset. It sits directly under the FPGA board pins (clock, reset button, USB-UART TX, 16 LEDs).

## Interface
- NB_INSTRUCTION, 16: instruction width; also accumulator, data-word and LED width.
- NB_ADDR, 11: program and data memory address width; depth 2^NB_ADDR.
- NB_OPCODE, 5: opcode field width, bits [15:11].
- NB_OPERAND, NB_INSTRUCTION-NB_OPCODE (11): operand field, bits [10:0].
- NB_DATA, 8: UART data bits per frame.
- NB_STOP, 1: UART stop bits.
- BAUD_RATE, 9600: serial baud rate.
- SYS_CLOCK, 100000000: clock frequency in Hz.
- TICK_RATE, SYS_CLOCK/(BAUD_RATE*16) (651): clocks per 16x oversampling tick.
- NB_TICK_COUNTER, $clog2(TICK_RATE): tick counter width.
- NB_DATA_COUNTER, $clog2(NB_DATA): UART bit counter width.

Ports:
- i_clock  in  1  system clock. This is the only clock; all logic runs on its rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- RsTx  out  1  UART serial output. Idles high.
- o_led  out  NB_INSTRUCTION  current accumulator value.

## Operation
- The instruction is {opcode[4:0], operand[10:0]}.
- The immediate is the operand sign-extended to 16 bits.
- The data address is operand[NB_ADDR-1:0].
- Opcodes:
  - 0 HLT: halt.
  - 1 STO: mem[addr] <= ACC.
  - 2 LD: ACC <= mem[addr].
  - 3 LDI: ACC <= imm.
  - 4 ADD: ACC <= ACC + mem[addr].
  - 5 ADDI: ACC <= ACC + imm.
  - 6 SUB: ACC <= ACC - mem[addr].
  - 7 SUBI: ACC <= ACC - imm.
  - Opcodes 8-31 are NOP: PC advances only.
- Arithmetic is 16-bit two's complement and wraps modulo 2^16. There are no flags.
- Program ROM: asynchronous read. Built-in contents:
  - 0: LDI 5
  - 1: STO 0
  - 2: ADDI 3
  - 3: ADD 0
  - 4: SUBI 1
  - 5: STO 1
  - 6: SUB 0
  - 7: LD 1
  - 8: HLT
  - All remaining words are 0 (HLT).
- Data RAM: asynchronous read, synchronous write. Initialised to 0 at configuration; not cleared by reset.
- The PC increments by 1 per executed instruction and wraps at 2^NB_ADDR.
- Halt sequence, after HLT:
  - PC and ACC freeze.
  - The halted flag is set.
  - The UART sends ACC[15:8] and then ACC[7:0], one frame each.
  - The flag stays set after transmission.
  - No further bytes are sent until reset.
- UART frame: start bit 0, NB_DATA data bits LSB first, NB_STOP stop bits of 1.
- Tick generator: one tick every TICK_RATE clocks; every bit lasts 16 ticks.
- Transmitter states: IDLE → START → DATA → STOP → (IDLE, or START for the second byte).
- o_led = ACC at all times.

## Timing
- Reset: while i_reset is high at a rising edge, registers load:
  - PC = 0, ACC = 0, halted = 0.
  - Transmitter IDLE, tick and bit counters = 0.
  - RsTx = 1, o_led = 0.
- Reset asserted mid-program or mid-frame aborts immediately. RsTx is high after that edge, and execution restarts from PC 0 after release.
- One instruction executes per clock, with results visible after the edge.
- Edge 1 is the first rising edge with i_reset low; it executes address 0. The built-in program gives:
  - After edge 1: ACC = 5.
  - After edge 8: ACC = 12 (0x000C), PC = 8.
  - Edge 9 executes HLT and sets the halted flag.
- The start bit of the first frame begins within TICK_RATE+1 clocks after halted sets.
- Bit duration is exactly 16*TICK_RATE clocks (10416).
- The second frame's start bit follows the first stop bit with no idle gap beyond one tick.
- After the second stop bit, RsTx stays high indefinitely.

## Test plan
- Reset: hold i_reset high for 3 clocks → o_led = 0x0000, RsTx = 1 throughout.
- Execution: release reset → o_led = 5 after edge 1, 8 after edge 3, 13 after edge 4, 7 after edge 7, 12 after edge 8; stays 0x000C afterwards.
- UART: after halt, decode RsTx at 10416 clocks/bit sampled mid-bit → byte 0x00 then byte 0x0C. Each frame has start = 0 and stop = 1, data bits are LSB first, and RsTx stays high afterwards.
- Bit timing: measure the falling edge of the start bit to the first data-bit change of byte 0x0C (bit 2 = 1) → exactly 3*10416 clocks.
- Reset mid-frame: assert i_reset during the second frame's data bits → RsTx = 1 after that edge and o_led = 0. After release, the full sequence repeats with identical values.
- No retransmit: run 10 ms after the second frame → no further falling edge on RsTx.
